simple_gray2bin: RTL
====================

Name: simple_gray2bin

Overview:
Register-mapped Gray-to-binary decoder. It is the receive-side counterpart of the existing binary-to-Gray block. The host writes Gray codes to the DATA register. Each code is decoded combinationally and pushed into an internal FIFO. The host reads the decoded binary values back through the same bus, with sticky status flags and a host-issued clear.

Parameters:
DATA_W, 8, width of data words and of the bus
DEPTH, 16, FIFO depth in entries; power of two, at least 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  bus select; no access occurs when low
addr  input  2  register address
write  input  1  write strobe
read  input  1  read strobe
wdata  input  DATA_W  write data
rdata  output  DATA_W  read data, registered
resp  output  1  error response, registered
irq  output  1  level interrupt, registered; high while FIFO holds at least one entry and no sticky flag is set

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Access qualification: acc = enable && rst_n. A write is wr = acc && write; a read is rd = acc && read. Asserting write and read together on the same address is legal; both take effect.
- Register map:
  - 0 DATA. A write pushes gray2bin(wdata). A read pops the FIFO head.
  - 1, 2 RSVD. Writes are ignored and raise resp. Reads return 0 and raise resp.
  - 3 CTL_STAT. Read value is {3'b0, 1'b0, underflow, overflow, full, empty}. A write with wdata[4]=1 clears the FIFO; any other write to this address has no effect.
- Decode: b[DATA_W-1] = g[DATA_W-1]; b[i] = b[i+1] ^ g[i]. Purely combinational, applied at push time.
- Read latency is 1 cycle. rdata and resp are updated on the clock edge after the access.
  - DATA read returns the head value present in the access cycle.
  - A cycle with no rd sets rdata=0 and resp=0.
- FIFO: circular buffer with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Boundary rules:
  - Push when full with no pop: data is dropped, overflow sticks to 1, and resp=1 next cycle.
  - Pop when empty: rdata=0, underflow sticks to 1, resp=1 next cycle, pointers unchanged.
  - Push and pop together when full: both succeed, count unchanged, no overflow.
  - Push and pop together when empty: the push succeeds; the pop is an underflow and returns 0 (no write-through).
- Clear (CTL_STAT write with bit4=1): on the next edge, pointers, count, overflow and underflow all go to 0. Clear has priority over any push or pop in the same cycle.
- enable=0: no state changes; rdata and resp go to 0 next cycle.
- Reset mid-operation: all contents are discarded immediately and asynchronously.
- Reset values: rdata=0, resp=0, irq=0, count=0, wr_ptr=0, rd_ptr=0, overflow=0, underflow=0; hence empty=1 and full=0. Memory contents are don't-care.

Decomposition:
- Package g2b_pkg:
  - address constants ADDR_DATA=0, ADDR_RSVD1=1, ADDR_RSVD2=2, ADDR_CTL=3
  - CTL_STAT bit indices BIT_EMPTY=0, BIT_FULL=1, BIT_OVF=2, BIT_UNF=3, BIT_CLR=4
  - typedef for the CTL_STAT packed struct
- Sub-module gray2bin: combinational, parameterised by DATA_W. FIFO storage and control stay in the top module.

Test Plan:
- Reset, then read addr 3 -> rdata=8'h01 one cycle later, resp=0, irq=0.
- Write addr 0 with 8'h0C, 8'hFF, 8'h80; then read addr 0 three times -> rdata 8'h08, 8'hAA, 8'hFF on successive cycles, irq falls after the last pop, and a final addr 3 read returns 8'h01.
- Push 17 words 8'h00..8'h10 (DEPTH=16) -> after the 16th push CTL_STAT=8'h02; the 17th push gives resp=1 and CTL_STAT=8'h06. Popping 16 times returns binary 0..15 decoded and drops 8'h10.
- Read addr 0 while empty -> rdata=0, resp=1, CTL_STAT=8'h09. Then write addr 3 with 8'h10 -> CTL_STAT=8'h01.
- Fill to full, then push and pop in the same cycle -> count stays 16, no overflow, and the popped value is the oldest entry. Then write 8'h10 to addr 3 together with a DATA push -> count=0.
- Read or write addr 1 or 2 -> resp=1, rdata=0, FIFO unchanged. With enable=0, toggle write and read at addr 0 -> no state change. Assert rst_n low mid-burst -> CTL_STAT=8'h01 immediately after release.

Source files
------------

// File: rtl/simple_gray2bin_pkg.sv
// Shared register map, CTL_STAT bit positions and status layout for the
// register-mapped Gray-to-binary decoder.
package g2b_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_RSVD1 = 2'd1;
    localparam logic [1:0] ADDR_RSVD2 = 2'd2;
    localparam logic [1:0] ADDR_CTL   = 2'd3;

    localparam int BIT_EMPTY = 0;
    localparam int BIT_FULL  = 1;
    localparam int BIT_OVF   = 2;
    localparam int BIT_UNF   = 3;
    localparam int BIT_CLR   = 4;

    // CTL_STAT read layout, MSB first; the clear bit always reads back as 0
    typedef struct packed {
        logic [2:0] rsvd_hi;
        logic       clr;
        logic       unf;
        logic       ovf;
        logic       full;
        logic       empty;
    } ctl_stat_t;

endpackage

// File: rtl/simple_gray2bin_gray2bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] gray,
    output logic [DATA_W-1:0] bin
);

    always_comb begin
        logic [DATA_W-1:0] b;
        b = gray;
        for (int i = DATA_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gray[i];
        end
        bin = b;
    end

endmodule

// File: rtl/simple_gray2bin.sv
// Register-mapped Gray-to-binary decoder: DATA writes are decoded and queued
// in a circular FIFO, DATA reads pop it, CTL_STAT reports and clears flags.
module simple_gray2bin
    import g2b_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        addr,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              resp,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              ovf, unf, ovf_nxt, unf_nxt;
    logic [DATA_W-1:0] rdata_nxt, dec;
    logic              resp_nxt, irq_nxt;

    logic acc, wr, rd;
    logic sel_data, sel_rsvd, sel_ctl;
    logic push_req, pop_req, clr;
    logic full, empty, do_push, do_pop, ovf_evt, unf_evt, rsvd_acc;
    ctl_stat_t  stat;
    logic [7:0] stat_bits;

    gray2bin #(.DATA_W(DATA_W)) u_dec (
        .gray (wdata),
        .bin  (dec)
    );

    assign acc      = enable && rst_n;
    assign wr       = acc && write;
    assign rd       = acc && read;
    assign sel_data = (addr == ADDR_DATA);
    assign sel_rsvd = (addr == ADDR_RSVD1) || (addr == ADDR_RSVD2);
    assign sel_ctl  = (addr == ADDR_CTL);

    assign push_req = wr && sel_data;
    assign pop_req  = rd && sel_data;
    assign clr      = wr && sel_ctl && wdata[BIT_CLR];

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign do_push  = push_req && (!full || pop_req);
    assign do_pop   = pop_req && !empty;
    assign ovf_evt  = push_req && full && !pop_req;
    assign unf_evt  = pop_req && empty;
    assign rsvd_acc = (wr || rd) && sel_rsvd;

    assign stat      = '{rsvd_hi: 3'b000, clr: 1'b0, unf: unf, ovf: ovf,
                         full: full, empty: empty};
    assign stat_bits = stat;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        ovf_nxt    = ovf;
        unf_nxt    = unf;
        if (clr) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
            ovf_nxt    = 1'b0;
            unf_nxt    = 1'b0;
        end else begin
            if (do_push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
            if (ovf_evt) ovf_nxt = 1'b1;
            if (unf_evt) unf_nxt = 1'b1;
        end
    end

    // Read data reflects the state seen during the access cycle
    always_comb begin
        rdata_nxt = '0;
        if (rd) begin
            case (addr)
                ADDR_DATA: rdata_nxt = empty ? '0 : mem[rd_ptr];
                ADDR_CTL:  rdata_nxt = DATA_W'(stat_bits);
                default:   rdata_nxt = '0;
            endcase
        end
        resp_nxt = rsvd_acc || ovf_evt || unf_evt;
        irq_nxt  = (count_nxt != '0) && !ovf_nxt && !unf_nxt;
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            rdata  <= '0;
            resp   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            ovf    <= ovf_nxt;
            unf    <= unf_nxt;
            rdata  <= rdata_nxt;
            resp   <= resp_nxt;
            irq    <= irq_nxt;
        end
    end

endmodule
